// File: rtl/famicom_pad_scheduler.sv
// Serialises a 32-bit snapshot of four pads (keyboard merged into slot 0) to the core on its latch/pulse strobes.
// famicom_data follows a raw pulse rise by 3 clk_sys cycles; stale reads are abandoned after TIMEOUT_CYCLES idle cycles.
module famicom_pad_scheduler #(
    parameter int   TIMEOUT_CYCLES = 20000,
    parameter logic FILL_BIT       = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       famicom_latch,
    input  logic       famicom_pulse,
    input  logic [7:0] pad0,
    input  logic [7:0] pad1,
    input  logic [7:0] pad2,
    input  logic [7:0] pad3,
    input  logic [7:0] kb_code,
    input  logic       kb_valid,
    output logic       famicom_data,
    output logic       busy,
    output logic       frame_done,
    output logic [5:0] bit_count
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [15:0] TIMEOUT_W = TIMEOUT_CYCLES[15:0];

    state_t      state, state_nxt;
    logic [31:0] snap, snap_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [15:0] idle, idle_nxt;
    logic        done_nxt;

    logic latch_s1, latch_s2, latch_hist;
    logic pulse_s1, pulse_s2, pulse_hist;
    logic latch_fall, latch_edge, pulse_rise, pulse_edge;
    logic [7:0]  slot0;
    logic [31:0] snap_in;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            latch_s1   <= 1'b0;
            latch_s2   <= 1'b0;
            latch_hist <= 1'b0;
            pulse_s1   <= 1'b0;
            pulse_s2   <= 1'b0;
            pulse_hist <= 1'b0;
        end else begin
            latch_s1   <= famicom_latch;
            latch_s2   <= latch_s1;
            latch_hist <= latch_s2;
            pulse_s1   <= famicom_pulse;
            pulse_s2   <= pulse_s1;
            pulse_hist <= pulse_s2;
        end
    end

    assign latch_fall = ~latch_s2 & latch_hist;
    assign latch_edge = latch_s2 ^ latch_hist;
    assign pulse_rise = pulse_s2 & ~pulse_hist;
    assign pulse_edge = pulse_s2 ^ pulse_hist;

    assign slot0   = kb_valid ? (pad0 | kb_code) : pad0;
    assign snap_in = {pad3, pad2, pad1, slot0};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            snap       <= {32{FILL_BIT}};
            cnt        <= 6'd0;
            idle       <= 16'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            snap       <= snap_nxt;
            cnt        <= cnt_nxt;
            idle       <= idle_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        snap_nxt  = snap;
        cnt_nxt   = cnt;
        idle_nxt  = idle;
        done_nxt  = 1'b0;
        // A held latch overrides everything, including a coincident pulse edge.
        if (latch_s2) begin
            state_nxt = LOAD;
            snap_nxt  = snap_in;
            cnt_nxt   = 6'd0;
            idle_nxt  = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt  = 6'd0;
                    idle_nxt = 16'd0;
                end
                LOAD: begin
                    idle_nxt = 16'd0;
                    if (latch_fall) state_nxt = SHIFT;
                end
                SHIFT, DONE: begin
                    if (state == SHIFT && pulse_rise) begin
                        snap_nxt = {FILL_BIT, snap[31:1]};
                        cnt_nxt  = cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                    if (latch_edge || pulse_edge) begin
                        idle_nxt = 16'd0;
                    end else if (idle >= TIMEOUT_W) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 6'd0;
                        idle_nxt  = 16'd0;
                    end else begin
                        idle_nxt = idle + 16'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign famicom_data = (state == LOAD || state == SHIFT) ? snap[0] : FILL_BIT;
    assign bit_count    = cnt;

endmodule

// File: doc/famicom_pad_scheduler.md
FAMICOM_PAD_SCHEDULER -- requirements
Module: famicom_pad_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000, is the number of idle clk_sys cycles after which an unfinished serial read is abandoned.
REQ-002 Parameter FILL_BIT, default 1'b1, is the value driven on famicom_data after all slots have been shifted out.
REQ-003 clk_sys  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 famicom_latch  input  1  latch strobe from the core; asynchronous to this block.
REQ-006 famicom_pulse  input  1  shift clock from the core; asynchronous to this block.
REQ-007 pad0..pad3  input  8 each  button state, active-high pressed; bit0 is shifted out first.
REQ-008 kb_code  input  8  keyboard byte in the same bit order as pad0.
REQ-009 kb_valid  input  1  keyboard byte is merged into slot 0 while high.
REQ-010 famicom_data  output  1  serial button bit to the core, active-high pressed.
REQ-011 busy  output  1  high in LOAD, SHIFT and DONE.
REQ-012 frame_done  output  1  one-cycle pulse when the 32nd shift completes.
REQ-013 bit_count  output  6  number of shifts performed since the last latch release, 0..32.

Function
REQ-014 famicom_latch and famicom_pulse SHALL each pass through a 2-flop synchronizer plus a history flop; an edge is detected as sync2 & ~hist for rising and ~sync2 & hist for falling.
REQ-015 The snapshot SHALL be 32 bits: {pad3, pad2, pad1, slot0}, where slot0 = pad0 | kb_code when kb_valid=1, else pad0.
REQ-016 The block SHALL implement four states: IDLE, LOAD, SHIFT and DONE.
REQ-017 In any state, a high synchronized latch SHALL force LOAD and reload the snapshot every cycle; famicom_data = snapshot bit0; bit_count = 0.
REQ-018 LOAD -> SHIFT SHALL occur on a falling latch edge; the snapshot is frozen from that cycle on.
REQ-019 In SHIFT, each rising pulse edge SHALL shift the snapshot right by one, insert FILL_BIT at bit31, and increment bit_count.
REQ-020 famicom_data SHALL be updated 3 clk_sys cycles after the raw pulse input rises.
REQ-021 When bit_count reaches 32, the block SHALL enter DONE, assert frame_done for one cycle, and hold famicom_data = FILL_BIT.
REQ-022 In DONE, further pulse edges SHALL be ignored and bit_count SHALL saturate at 32.
REQ-023 A 16-bit idle counter SHALL clear on any latch or pulse edge and increment in SHIFT and DONE; at TIMEOUT_CYCLES it SHALL force IDLE.
REQ-024 In IDLE, famicom_data = FILL_BIT, busy = 0 and bit_count = 0; pulse edges SHALL be ignored.
REQ-025 Latch priority: if a latch rise and a pulse rise are detected in the same cycle, the latch wins and no shift occurs.
REQ-026 Pad and keyboard inputs SHALL be sampled only in LOAD; changes during SHIFT SHALL not affect the output.

Reset
REQ-027 On reset, state = IDLE, snapshot = all FILL_BIT, the synchronizer and history flops = 0, and the idle counter = 0.
REQ-028 Reset output values: famicom_data = FILL_BIT, busy = 0, frame_done = 0, bit_count = 0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the frame with no frame_done pulse; the first latch after release SHALL start a clean frame.

Verification
REQ-030 Single-pad read: pad0=8'h05, others 0, latch pulse then 8 pulses -> famicom_data sequence 1,0,1,0,0,0,0,0; bit_count = 8.
REQ-031 Full read: pad0..pad3 = 8'h01, 8'h02, 8'h04, 8'h80, latch then 32 pulses -> 1s at bit indices 0, 9, 18, 31; frame_done pulses once; further pulses keep data = 1 and bit_count = 32.
REQ-032 Keyboard merge: pad0=8'h10, kb_code=8'h01, kb_valid=1 during latch -> first two bits 1,0, fifth bit 1; changing kb_code during SHIFT has no effect.
REQ-033 Timeout: latch then 5 pulses then TIMEOUT_CYCLES idle cycles -> state IDLE, busy = 0, data = 1, bit_count = 0, no frame_done.
REQ-034 Re-latch: latch asserted after 12 pulses -> bit_count returns to 0 and data = new pad0 bit0 within 3 cycles.
REQ-035 Reset mid-frame: reset after 20 pulses -> all outputs at reset values next cycle, no frame_done; the next full read returns correct data.
